// File: rtl/spram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spram_pkg                                                  |
// | Description : Shared types and helpers for the single-port RAM bank     |
// |               controller: FSM state encoding, bank-local address width, |
// |               and byte-mask to primitive nibble-mask mapping.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package spram_pkg;

    // Word-address width inside one 16K-deep bank.
    localparam int c_BANK_AW = 14;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        STDBY  = 2'd1,
        WAKE   = 2'd2
    } spram_state_t;

    // A 16-bit primitive writes in nibbles. Its two byte enables each
    // cover two nibbles, so {b1, b0} expands to {b1, b1, b0, b0}.
    function automatic logic [3:0] nibble_mask(input logic [1:0] byte_en);
        return {byte_en[1], byte_en[1], byte_en[0], byte_en[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/SP256K.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : SP256K                                                     |
// | Description : Behavioural stand-in for the 16K x 16 single-port RAM     |
// |               primitive. Exclude this file when the vendor cell library |
// |               supplies the real SP256K.                                 |
// | Ports       : AD[13:0] address, DI[15:0] write data, MASKWE[3:0] nibble |
// |               write enables (1 = write), WE write strobe, CS select,    |
// |               CK clock, STDBY/SLEEP/PWROFF_N power controls,            |
// |               DO[15:0] registered read data (holds between reads).      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module SP256K (
    input  logic [13:0] AD,
    input  logic [15:0] DI,
    input  logic [3:0]  MASKWE,
    input  logic        WE,
    input  logic        CS,
    input  logic        CK,
    input  logic        STDBY,
    input  logic        SLEEP,
    input  logic        PWROFF_N,
    output logic [15:0] DO
);

    logic [15:0] r_mem [0:16383];
    logic [15:0] r_do;
    logic [15:0] w_old;
    logic [15:0] w_new;
    logic        w_live;

    // Accesses are ignored unless the array is fully powered.
    assign w_live = CS && !STDBY && !SLEEP && PWROFF_N;
    assign w_old  = r_mem[AD];

    always_comb begin
        w_new = w_old;
        for (int n = 0; n < 4; n++) begin
            if (MASKWE[n]) begin
                w_new[4*n +: 4] = DI[4*n +: 4];
            end
        end
    end

    always_ff @(posedge CK) begin
        if (w_live) begin
            if (WE) begin
                r_mem[AD] <= w_new;
            end else begin
                r_do <= w_old;
            end
        end
    end

    assign DO = r_do;

endmodule
`default_nettype wire

// File: rtl/spram_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spram_bank                                                 |
// | Description : One DW-wide, 16K-deep bank built from DW/16 SP256K       |
// |               primitives side by side.                                  |
// | Ports       : clk clock; i_cs chip select; i_we write strobe;           |
// |               i_addr bank-local word address; i_wdata write data;       |
// |               i_bmsk byte enables; i_stdby standby to all primitives;   |
// |               o_rdata registered read data.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module spram_bank
    import spram_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 i_cs,
    input  logic                 i_we,
    input  logic [c_BANK_AW-1:0] i_addr,
    input  logic [DW-1:0]        i_wdata,
    input  logic [DW/8-1:0]      i_bmsk,
    input  logic                 i_stdby,
    output logic [DW-1:0]        o_rdata
);

    localparam int c_NPRIM = DW / 16;

    genvar p;
    generate
        for (p = 0; p < c_NPRIM; p++) begin : g_prim
            logic [3:0] w_maskwe;
            assign w_maskwe = nibble_mask(i_bmsk[2*p +: 2]);

            SP256K u_prim (
                .AD       (i_addr),
                .DI       (i_wdata[16*p +: 16]),
                .MASKWE   (w_maskwe),
                .WE       (i_we),
                .CS       (i_cs),
                .CK       (clk),
                .STDBY    (i_stdby),
                .SLEEP    (1'b0),
                .PWROFF_N (1'b1),
                .DO       (o_rdata[16*p +: 16])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/spram_bank_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : spram_bank_ctl                                             |
// | Description : Request/ready front end for NBANK single-port RAM banks   |
// |               with idle-driven standby and a one-cycle wake.            |
// | Ports       : clk, rst_n (async, active low); req/rdy handshake;        |
// |               we, addr, bmsk, wdata request qualifiers; rdata/rvalid    |
// |               read return one cycle after acceptance; stdby status.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module spram_bank_ctl
    import spram_pkg::*;
#(
    parameter  int DW       = 32,
    parameter  int NBANK    = 2,
    parameter  int IDLE_CYC = 64,
    localparam int AW       = c_BANK_AW + $clog2(NBANK)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    output logic            rdy,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [DW/8-1:0] bmsk,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata,
    output logic            rvalid,
    output logic            stdby
);

    localparam int c_BW = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int c_CW = (IDLE_CYC > 1) ? $clog2(IDLE_CYC) : 1;
    // Last count value before the one that would equal IDLE_CYC.
    localparam logic [c_CW-1:0] c_IDLE_LAST = c_CW'((IDLE_CYC > 0) ? IDLE_CYC - 1 : 0);

    spram_state_t    r_state;
    spram_state_t    w_state_nxt;
    logic [c_CW-1:0] r_idle_cnt;
    logic [c_CW-1:0] w_idle_cnt_nxt;

    logic [c_BW-1:0] w_bank_idx;
    logic [c_BW-1:0] r_sel;
    logic            r_rvalid;
    logic [DW-1:0]   r_rdata_hold;
    logic            w_xfer;
    logic            w_rd_xfer;
    logic            w_bank_stdby;
    logic [DW-1:0]   w_bank_rdata [NBANK];

    assign rdy          = (r_state == ACTIVE);
    assign stdby        = (r_state == STDBY);
    assign w_bank_stdby = (r_state == STDBY);
    assign w_xfer       = req && rdy;
    assign w_rd_xfer    = w_xfer && !we;

    generate
        if (NBANK > 1) begin : g_multi_bank
            assign w_bank_idx = addr[AW-1:c_BANK_AW];
        end else begin : g_single_bank
            assign w_bank_idx = '0;
        end
    endgenerate

    // The idle cycle that would carry the count to IDLE_CYC is the one
    // that moves the FSM into standby; a request on that cycle wins.
    always_comb begin
        w_state_nxt    = r_state;
        w_idle_cnt_nxt = r_idle_cnt;
        case (r_state)
            ACTIVE: begin
                if (req) begin
                    w_idle_cnt_nxt = '0;
                end else if (IDLE_CYC != 0) begin
                    if (r_idle_cnt == c_IDLE_LAST) begin
                        w_state_nxt    = STDBY;
                        w_idle_cnt_nxt = '0;
                    end else begin
                        w_idle_cnt_nxt = r_idle_cnt + c_CW'(1);
                    end
                end
            end
            STDBY: begin
                w_idle_cnt_nxt = '0;
                if (req) begin
                    w_state_nxt = WAKE;
                end
            end
            WAKE: begin
                w_idle_cnt_nxt = '0;
                w_state_nxt    = ACTIVE;
            end
            default: begin
                w_idle_cnt_nxt = '0;
                w_state_nxt    = ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ACTIVE;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
        end
    end

    // Read return path. The primitives register their output on the
    // acceptance edge, so the bank's DO is presented directly during the
    // rvalid cycle and latched into a hold register for the cycles after,
    // which keeps rdata stable even if a later write touches the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid     <= 1'b0;
            r_sel        <= '0;
            r_rdata_hold <= '0;
        end else begin
            r_rvalid <= w_rd_xfer;
            if (w_rd_xfer) begin
                r_sel <= w_bank_idx;
            end
            if (r_rvalid) begin
                r_rdata_hold <= w_bank_rdata[r_sel];
            end
        end
    end

    assign rvalid = r_rvalid;
    assign rdata  = r_rvalid ? w_bank_rdata[r_sel] : r_rdata_hold;

    genvar b;
    generate
        for (b = 0; b < NBANK; b++) begin : g_bank
            logic w_cs;
            assign w_cs = w_xfer && (w_bank_idx == c_BW'(b));

            spram_bank #(
                .DW (DW)
            ) u_bank (
                .clk     (clk),
                .i_cs    (w_cs),
                .i_we    (we),
                .i_addr  (addr[c_BANK_AW-1:0]),
                .i_wdata (wdata),
                .i_bmsk  (bmsk),
                .i_stdby (w_bank_stdby),
                .o_rdata (w_bank_rdata[b])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_spram_bank_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_spram_bank_ctl                                          |
// | Description : Self-checking bench for spram_bank_ctl (DW=32, NBANK=2,   |
// |               IDLE_CYC=4): vector table plus standby, collision and     |
// |               mid-read reset sequences.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_spram_bank_ctl;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        rdy;
    logic        we;
    logic [14:0] addr;
    logic [3:0]  bmsk;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        stdby;

    int n_cmp  = 0;
    int n_fail = 0;

    spram_bank_ctl #(
        .DW       (32),
        .NBANK    (2),
        .IDLE_CYC (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .rdy    (rdy),
        .we     (we),
        .addr   (addr),
        .bmsk   (bmsk),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .stdby  (stdby)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        req;
        logic        we;
        logic [14:0] addr;
        logic [3:0]  bmsk;
        logic [31:0] wdata;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a request until the controller accepts it; returns just after
    // the acceptance edge with req dropped.
    task automatic access(input logic i_we, input logic [14:0] i_addr,
                          input logic [3:0] i_bmsk, input logic [31:0] i_wdata);
        logic accepted;
        accepted = 1'b0;
        req   = 1'b1;
        we    = i_we;
        addr  = i_addr;
        bmsk  = i_bmsk;
        wdata = i_wdata;
        for (int k = 0; k < 8 && !accepted; k++) begin
            accepted = rdy;
            step();
        end
        req = 1'b0;
        if (!accepted) begin
            n_cmp++;
            n_fail++;
            $display("FAIL access_timeout: got no acceptance, expected acceptance within 8 cycles (addr %h)", i_addr);
        end
    endtask

    task automatic read_check(input string name, input logic [14:0] a, input logic [31:0] exp);
        access(1'b0, a, 4'h0, 32'h0);
        check({name, "_rvalid"}, {31'b0, rvalid}, 32'd1);
        check({name, "_rdata"}, rdata, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        bmsk  = '0;
        wdata = '0;

        //            req   we    addr      bmsk  wdata         rv    rdata
        vecs[0]  = '{1'b1, 1'b1, 15'h0005, 4'hF, 32'hDEADBEEF, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b0, 15'h0005, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b1, 15'h4001, 4'hF, 32'h11223344, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b1, 15'h4001, 4'h5, 32'hAABBCCDD, 1'b0, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b0, 15'h4001, 4'h0, 32'h0,        1'b1, 32'h11BB33DD};
        vecs[5]  = '{1'b1, 1'b1, 15'h0010, 4'hF, 32'h00000001, 1'b0, 32'h11BB33DD};
        vecs[6]  = '{1'b1, 1'b1, 15'h4010, 4'hF, 32'h00000002, 1'b0, 32'h11BB33DD};
        vecs[7]  = '{1'b1, 1'b0, 15'h0010, 4'h0, 32'h0,        1'b1, 32'h00000001};
        vecs[8]  = '{1'b1, 1'b0, 15'h4010, 4'h0, 32'h0,        1'b1, 32'h00000002};
        vecs[9]  = '{1'b1, 1'b1, 15'h4010, 4'hF, 32'h12345678, 1'b0, 32'h00000002};
        vecs[10] = '{1'b1, 1'b0, 15'h0005, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF};
        vecs[11] = '{1'b0, 1'b0, 15'h0000, 4'h0, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[12] = '{1'b1, 1'b0, 15'h4010, 4'h0, 32'h0,        1'b1, 32'h12345678};
        vecs[13] = '{1'b1, 1'b1, 15'h0005, 4'h8, 32'h55000000, 1'b0, 32'h12345678};
        vecs[14] = '{1'b1, 1'b0, 15'h0005, 4'h0, 32'h0,        1'b1, 32'h55ADBEEF};
        vecs[15] = '{1'b1, 1'b0, 15'h4001, 4'h0, 32'h0,        1'b1, 32'h11BB33DD};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_rvalid", {31'b0, rvalid}, 32'd0);
        check("reset_rdata",  rdata,           32'd0);
        check("reset_stdby",  {31'b0, stdby},  32'd0);
        check("reset_rdy",    {31'b0, rdy},    32'd1);
        rst_n = 1'b1;

        // Vector table: one transfer (or idle) per cycle
        for (int i = 0; i < 16; i++) begin
            req   = vecs[i].req;
            we    = vecs[i].we;
            addr  = vecs[i].addr;
            bmsk  = vecs[i].bmsk;
            wdata = vecs[i].wdata;
            step();
            check($sformatf("vec%0d_rvalid", i), {31'b0, rvalid}, {31'b0, vecs[i].exp_rvalid});
            check($sformatf("vec%0d_rdata", i),  rdata,           vecs[i].exp_rdata);
            check($sformatf("vec%0d_rdy", i),    {31'b0, rdy},    32'd1);
        end
        req = 1'b0;

        // Standby entry after 4 idle cycles
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("idle%0d_stdby", k), {31'b0, stdby}, (k == 4) ? 32'd1 : 32'd0);
            check($sformatf("idle%0d_rdy", k),   {31'b0, rdy},   (k == 4) ? 32'd0 : 32'd1);
        end
        step();
        check("stdby_hold", {31'b0, stdby}, 32'd1);

        // Wake: rdy low for 2 cycles, accepted on the 3rd
        req  = 1'b1;
        we   = 1'b0;
        addr = 15'h4010;
        check("wake_c1_rdy", {31'b0, rdy}, 32'd0);
        step();
        check("wake_c2_rdy",   {31'b0, rdy},   32'd0);
        check("wake_c2_stdby", {31'b0, stdby}, 32'd0);
        step();
        check("wake_c3_rdy",    {31'b0, rdy},    32'd1);
        check("wake_c3_rvalid", {31'b0, rvalid}, 32'd0);
        step();
        req = 1'b0;
        check("wake_rd_rvalid", {31'b0, rvalid}, 32'd1);
        check("wake_rd_rdata",  rdata,           32'h12345678);

        // Request on the cycle the idle count reaches the threshold
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("coll_idle%0d_stdby", k), {31'b0, stdby}, 32'd0);
        end
        req  = 1'b1;
        we   = 1'b0;
        addr = 15'h0010;
        step();
        req = 1'b0;
        check("coll_stdby",  {31'b0, stdby},  32'd0);
        check("coll_rvalid", {31'b0, rvalid}, 32'd1);
        check("coll_rdata",  rdata,           32'h00000001);
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("post_coll_idle%0d_stdby", k), {31'b0, stdby}, (k == 4) ? 32'd1 : 32'd0);
        end

        // Data survives standby
        read_check("stdby_wake_rd", 15'h4001, 32'h11BB33DD);

        // Reset in the cycle after a read is accepted
        access(1'b0, 15'h0005, 4'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_mid_rdata",  rdata,           32'd0);
        step();
        step();
        rst_n = 1'b1;
        check("rst_rel_rdy", {31'b0, rdy}, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("rst_rel%0d_rvalid", k), {31'b0, rvalid}, 32'd0);
        end
        read_check("post_rst_rd0", 15'h0005, 32'h55ADBEEF);
        read_check("post_rst_rd1", 15'h4010, 32'h12345678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spram_bank_ctl.md
SPRAM_BANK_CTL -- requirements
Module: spram_bank_ctl

Interface
REQ-001 SHALL take parameter DW, default 32, data width in bits, a multiple of 16 with minimum 16.
REQ-002 SHALL take parameter NBANK, default 2, number of 16K-word depth banks; power of two, 1..4.
REQ-003 SHALL take parameter IDLE_CYC, default 64, idle cycles before banks enter standby; 0 disables standby.
REQ-004 SHALL derive AW = 14 + log2(NBANK) as the word-address width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req  in  1  access request, held with its qualifiers until accepted.
REQ-008 rdy  out  1  controller can accept; a transfer occurs on a cycle with req && rdy.
REQ-009 we  in  1  1 = write, 0 = read.
REQ-010 addr  in  AW  word address; addr[AW-1:14] selects the bank, addr[13:0] is the bank-local word.
REQ-011 bmsk  in  DW/8  byte write enables; bit i covers wdata[8i+7:8i].
REQ-012 wdata  in  DW  write data.
REQ-013 rdata  out  DW  read data, valid only while rvalid = 1.
REQ-014 rvalid  out  1  one-cycle pulse marking rdata valid.
REQ-015 stdby  out  1  1 while the banks are held in standby.

Function
REQ-016 SHALL implement FSM states ACTIVE, STDBY and WAKE.
REQ-017 ACTIVE: rdy = 1; each accepted transfer SHALL reset the idle counter; each cycle without req SHALL increment it.
REQ-018 ACTIVE -> STDBY SHALL occur when the idle counter reaches IDLE_CYC with req = 0; if req = 1 on that cycle, the request wins and the counter clears.
REQ-019 STDBY: rdy = 0 and stdby = 1; every bank's STDBY pin SHALL be driven 1; req = 1 SHALL cause the transition STDBY -> WAKE.
REQ-020 WAKE SHALL last exactly 1 cycle with rdy = 0 and STDBY pins 0, then return to ACTIVE; wake-up latency from req to rdy is 2 cycles.
REQ-021 An accepted transfer SHALL chip-select only the addressed bank; all other banks SHALL have CS = 0.
REQ-022 A write SHALL update only the bytes whose bmsk bit is set; each 16-bit primitive nibble mask SHALL be {b1,b1,b0,b0} from its two byte bits.
REQ-023 A read SHALL assert rvalid exactly 1 cycle after acceptance, with rdata taken from the bank captured in a registered select at acceptance.
REQ-024 Back-to-back reads SHALL sustain one transfer per cycle, with rdata and rvalid pipelined one cycle behind.
REQ-025 A write accepted on the cycle after a read SHALL NOT corrupt that read's rdata.
REQ-026 A write SHALL NOT produce rvalid.
REQ-027 rdata SHALL hold its last value when rvalid = 0.
REQ-028 SLEEP SHALL be driven 0 and PWROFF_N 1 on every primitive.

Reset
REQ-029 rst_n = 0 SHALL force, asynchronously: state ACTIVE, idle counter 0, rvalid 0, rdata 0, stdby 0, bank select register 0.
REQ-030 A read in flight when reset asserts SHALL be dropped, with no rvalid after release.
REQ-031 rdy SHALL be 1 on the first clock edge after rst_n deasserts.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-033 Package spram_pkg SHALL hold the FSM state enum, the bank-address width constant (14) and a function mapping a byte mask to primitive nibble masks.
REQ-034 Sub-module spram_bank SHALL wrap DW/16 SP256K primitives as one DW-wide, 16K-deep bank, instantiated NBANK times through generate.

Verification
REQ-035 Defaults: write 0xDEADBEEF to 0x0005, bmsk 0xF, then read 0x0005 -> rvalid pulses 1 cycle after the read is accepted, rdata = 0xDEADBEEF.
REQ-036 Byte mask: write 0x11223344 to 0x4001, then write 0xAABBCCDD with bmsk 0x5, then read -> 0x11BB33DD.
REQ-037 Bank isolation: write 0x1 to 0x0010 and 0x2 to 0x4010, then read both back to back -> rdata 0x1 then 0x2 on consecutive cycles.
REQ-038 Standby, IDLE_CYC = 4: 4 idle cycles -> stdby = 1; then req -> rdy low 2 cycles and transfer accepted on the 3rd; earlier data intact.
REQ-039 Threshold collision: req arrives on the cycle the idle counter reaches 4 -> accepted, stdby stays 0.
REQ-040 Reset mid-read: rst_n pulsed low on the cycle after read acceptance -> rvalid never asserts, rdy = 1 after release, prior contents intact.
